// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - HPS ROM download sequencer and core reset control
//
// Optional feature macro: ROM_LOAD_CHECKSUM_EN (live additive checksum and
// checksum mismatch folded into load_err; EXPECT_SUM exists only with it).
//
// Ports:
//   clk_sys       system clock
//   Reset_n       asynchronous active-low reset
//   dn_download   HPS download in progress
//   dn_wr         byte write strobe, one cycle per byte
//   dn_addr       17-bit download byte address
//   dn_data       download byte data
//   rom_wr        one-hot region strobe {PROM, MOB, CHAR, PROG}, registered
//   rom_addr      region-local byte address, registered
//   rom_data      registered write data
//   core_reset_n  active-low reset to the game core, high only in RUN
//   busy          high in LOAD, DRAIN or SETTLE
//   load_err      sticky result of the last completed load
//   byte_count    bytes accepted in the current or last load (saturating)
//   checksum      running additive sum of accepted bytes (0 without macro)
`timescale 1ns/1ps
module rom_load_sequencer #(
   parameter logic [16:0] PROG_BASE     = 17'h00000,
   parameter int          PROG_SIZE     = 8192,
   parameter logic [16:0] CHAR_BASE     = 17'h02000,
   parameter int          CHAR_SIZE     = 2048,
   parameter logic [16:0] MOB_BASE      = 17'h02800,
   parameter int          MOB_SIZE      = 2048,
   parameter logic [16:0] PROM_BASE     = 17'h03000,
   parameter int          PROM_SIZE     = 256,
   parameter int          SETTLE_CYCLES = 1024
`ifdef ROM_LOAD_CHECKSUM_EN
   ,
   parameter logic [7:0]  EXPECT_SUM    = 8'h00
`endif
) (
   input  logic        clk_sys,
   input  logic        Reset_n,
   input  logic        dn_download,
   input  logic        dn_wr,
   input  logic [16:0] dn_addr,
   input  logic [7:0]  dn_data,
   output logic [3:0]  rom_wr,
   output logic [12:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        core_reset_n,
   output logic        busy,
   output logic        load_err,
   output logic [16:0] byte_count,
   output logic [7:0]  checksum
);

   localparam logic [16:0] TOTAL_BYTES = 17'(PROG_SIZE + CHAR_SIZE + MOB_SIZE + PROM_SIZE);
   localparam int          CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_WAIT,
      S_LOAD,
      S_DRAIN,
      S_SETTLE,
      S_RUN
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] settle_cnt;
   logic          range_err;
   logic          load_entry;
   logic          accept;
   logic          ck_err;

   logic [17:0]   off_prog, off_char, off_mob, off_prom;
   logic [3:0]    hit;
   logic [12:0]   local_addr;

   // Offsets are taken one bit wider than the address so an address below
   // a base wraps to a huge value and fails the single "< size" test.
   assign off_prog = {1'b0, dn_addr} - {1'b0, PROG_BASE};
   assign off_char = {1'b0, dn_addr} - {1'b0, CHAR_BASE};
   assign off_mob  = {1'b0, dn_addr} - {1'b0, MOB_BASE};
   assign off_prom = {1'b0, dn_addr} - {1'b0, PROM_BASE};

   always_comb begin
      hit        = 4'b0000;
      local_addr = 13'h0000;
      if (off_prog < 18'(PROG_SIZE)) begin
         hit[0]     = 1'b1;
         local_addr = off_prog[12:0];
      end else if (off_char < 18'(CHAR_SIZE)) begin
         hit[1]     = 1'b1;
         local_addr = off_char[12:0];
      end else if (off_mob < 18'(MOB_SIZE)) begin
         hit[2]     = 1'b1;
         local_addr = off_mob[12:0];
      end else if (off_prom < 18'(PROM_SIZE)) begin
         hit[3]     = 1'b1;
         local_addr = off_prom[12:0];
      end
   end

   // The write seen in the cycle dn_download falls is still taken because
   // the state is still LOAD during that cycle.
   assign accept = (state == S_LOAD) && dn_wr;

   always_comb begin
      state_n = state;
      case (state)
         S_WAIT:   if (dn_download) state_n = S_LOAD;
         S_LOAD:   if (!dn_download) state_n = S_DRAIN;
         S_DRAIN:  state_n = dn_download ? S_LOAD : S_SETTLE;
         S_SETTLE: begin
            if (dn_download)                   state_n = S_LOAD;
            else if (settle_cnt == SETTLE_LAST) state_n = S_RUN;
         end
         S_RUN:    if (dn_download) state_n = S_LOAD;
         default:  state_n = S_WAIT;
      endcase
   end

   assign load_entry   = (state_n == S_LOAD) && (state != S_LOAD);
   assign busy         = (state == S_LOAD) || (state == S_DRAIN) || (state == S_SETTLE);
   assign core_reset_n = (state == S_RUN);

   always_ff @(posedge clk_sys or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= S_WAIT;
         rom_wr     <= 4'b0000;
         rom_addr   <= 13'h0000;
         rom_data   <= 8'h00;
         load_err   <= 1'b0;
         range_err  <= 1'b0;
         byte_count <= 17'h00000;
         settle_cnt <= '0;
      end else begin
         state  <= state_n;
         rom_wr <= accept ? hit : 4'b0000;
         if (accept && (hit != 4'b0000)) begin
            rom_addr <= local_addr;
            rom_data <= dn_data;
         end

         if (load_entry) begin
            byte_count <= 17'h00000;
            range_err  <= 1'b0;
            load_err   <= 1'b0;
         end else begin
            if (accept) begin
               if (hit == 4'b0000)
                  range_err <= 1'b1;
               else if (byte_count != 17'h1FFFF)
                  byte_count <= byte_count + 17'd1;
            end
            if (state == S_DRAIN)
               load_err <= range_err || (byte_count != TOTAL_BYTES) || ck_err;
         end

         if (state == S_SETTLE)
            settle_cnt <= settle_cnt + CW'(1);
         else
            settle_cnt <= '0;
      end
   end

`ifdef ROM_LOAD_CHECKSUM_EN
   logic [7:0] sum_q;

   always_ff @(posedge clk_sys or negedge Reset_n) begin
      if (!Reset_n)
         sum_q <= 8'h00;
      else if (load_entry)
         sum_q <= 8'h00;
      else if (accept && (hit != 4'b0000))
         sum_q <= sum_q + dn_data;
   end

   assign checksum = sum_q;
   assign ck_err   = (sum_q != EXPECT_SUM);
`else
   assign checksum = 8'h00;
   assign ck_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb/tb_rom_load_sequencer.sv - self-checking bench for rom_load_sequencer
`timescale 1ns/1ps
module tb_rom_load_sequencer;

   localparam int S        = 20;
   localparam int FULL     = 12544;
`ifdef ROM_LOAD_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic        clk_sys = 1'b0;
   logic        Reset_n;
   logic        dn_download;
   logic        dn_wr;
   logic [16:0] dn_addr;
   logic [7:0]  dn_data;
   logic [3:0]  rom_wr;
   logic [12:0] rom_addr;
   logic [7:0]  rom_data;
   logic        core_reset_n;
   logic        busy;
   logic        load_err;
   logic [16:0] byte_count;
   logic [7:0]  checksum;

   always #5 clk_sys = ~clk_sys;

   rom_load_sequencer #(
      .SETTLE_CYCLES(S)
`ifdef ROM_LOAD_CHECKSUM_EN
      , .EXPECT_SUM(8'h5A)
`endif
   ) dut (
      .clk_sys(clk_sys), .Reset_n(Reset_n), .dn_download(dn_download),
      .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
      .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data),
      .core_reset_n(core_reset_n), .busy(busy), .load_err(load_err),
      .byte_count(byte_count), .checksum(checksum)
   );

   typedef struct {
      logic [3:0]  wr;
      logic [12:0] addr;
      logic [7:0]  data;
   } sb_t;

   typedef struct {
      logic [16:0] addr;
      logic [7:0]  data;
      logic [3:0]  exp_wr;
      logic [12:0] exp_addr;
      logic [16:0] exp_count;
   } vec_t;

   sb_t   sb_q[$];
   vec_t  vt[12];
   int    checks = 0;
   int    errors = 0;
   bit    sb_on  = 1'b1;

   int          m_count;
   bit          m_range;
   logic [7:0]  m_sum;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk_sys) begin
      if (sb_on && (rom_wr != 4'b0000)) begin
         if (sb_q.size() == 0) begin
            chk("unexpected strobe", {28'h0, rom_wr}, 32'h0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("sb rom_wr", {28'h0, rom_wr}, {28'h0, e.wr});
            chk("sb rom_addr", {19'h0, rom_addr}, {19'h0, e.addr});
            chk("sb rom_data", {24'h0, rom_data}, {24'h0, e.data});
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      m_count = 0;
      m_range = 1'b0;
      m_sum   = 8'h00;
   endtask

   task automatic begin_load();
      dn_download = 1'b1;
      @(posedge clk_sys); #1;
      model_clear();
      chk("load entry byte_count", {15'h0, byte_count}, 32'h0);
      chk("load entry busy", {31'h0, busy}, 32'h1);
      chk("load entry core_reset_n", {31'h0, core_reset_n}, 32'h0);
      chk("load entry load_err", {31'h0, load_err}, 32'h0);
   endtask

   // Drives n sequential bytes from address 0, one per clock. The final byte
   // is chosen so the additive sum of the stream equals target.
   task automatic load_bytes(input int n, input logic [7:0] target, input bit drop);
      for (int i = 0; i < n; i++) begin
         logic [16:0] a;
         logic [7:0]  d;
         sb_t         e;
         a = 17'(i);
         if (i == n - 1) d = target - m_sum;
         else            d = a[7:0] ^ {a[12:8], 3'b101};
         if (i < 32'h2000)      begin e.wr = 4'b0001; e.addr = 13'(i); end
         else if (i < 32'h2800) begin e.wr = 4'b0010; e.addr = 13'(i - 32'h2000); end
         else if (i < 32'h3000) begin e.wr = 4'b0100; e.addr = 13'(i - 32'h2800); end
         else                   begin e.wr = 4'b1000; e.addr = 13'(i - 32'h3000); end
         e.data = d;
         sb_q.push_back(e);
         m_count++;
         m_sum = m_sum + d;
         dn_wr   = 1'b1;
         dn_addr = a;
         dn_data = d;
         if (drop && (i == n - 1)) dn_download = 1'b0;
         @(posedge clk_sys); #1;
      end
      dn_wr = 1'b0;
   endtask

   // Called #1 after the edge that entered DRAIN.
   task automatic expect_release(input string name);
      int   n;
      logic exp_err;
      exp_err = m_range || (m_count != FULL) || (CK && (m_sum != 8'h5A));
      chk({name, " drain busy"}, {31'h0, busy}, 32'h1);
      n = 0;
      while (n < S + 10) begin
         @(posedge clk_sys); #1;
         n++;
         if (n == 1) chk({name, " load_err early"}, {31'h0, load_err}, {31'h0, exp_err});
         if (core_reset_n) break;
      end
      chk({name, " release cycles"}, n, S + 1);
      chk({name, " load_err"}, {31'h0, load_err}, {31'h0, exp_err});
      chk({name, " byte_count"}, {15'h0, byte_count}, m_count);
      chk({name, " checksum"}, {24'h0, checksum}, CK ? {24'h0, m_sum} : 32'h0);
      chk({name, " run busy"}, {31'h0, busy}, 32'h0);
      chk({name, " sb empty"}, sb_q.size(), 32'h0);
   endtask

   initial begin
      vt[0]  = '{17'h00000, 8'h11, 4'b0001, 13'h0000, 17'd1};
      vt[1]  = '{17'h01FFF, 8'h22, 4'b0001, 13'h1FFF, 17'd2};
      vt[2]  = '{17'h02000, 8'h33, 4'b0010, 13'h0000, 17'd3};
      vt[3]  = '{17'h027FF, 8'h44, 4'b0010, 13'h07FF, 17'd4};
      vt[4]  = '{17'h02800, 8'h55, 4'b0100, 13'h0000, 17'd5};
      vt[5]  = '{17'h02801, 8'h66, 4'b0100, 13'h0001, 17'd6};
      vt[6]  = '{17'h02FFF, 8'h77, 4'b0100, 13'h07FF, 17'd7};
      vt[7]  = '{17'h03000, 8'h88, 4'b1000, 13'h0000, 17'd8};
      vt[8]  = '{17'h030FF, 8'h99, 4'b1000, 13'h00FF, 17'd9};
      vt[9]  = '{17'h03100, 8'hAA, 4'b0000, 13'h0000, 17'd9};
      vt[10] = '{17'h04000, 8'hBB, 4'b0000, 13'h0000, 17'd9};
      vt[11] = '{17'h1FFFF, 8'hCC, 4'b0000, 13'h0000, 17'd9};

      Reset_n = 1'b0; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
      model_clear();
      repeat (3) @(posedge clk_sys);
      #1 Reset_n = 1'b1;
      repeat (10) @(posedge clk_sys);
      #1;
      chk("idle core_reset_n", {31'h0, core_reset_n}, 32'h0);
      chk("idle rom_wr", {28'h0, rom_wr}, 32'h0);
      chk("idle rom_addr", {19'h0, rom_addr}, 32'h0);
      chk("idle rom_data", {24'h0, rom_data}, 32'h0);
      chk("idle busy", {31'h0, busy}, 32'h0);
      chk("idle load_err", {31'h0, load_err}, 32'h0);
      chk("idle byte_count", {15'h0, byte_count}, 32'h0);
      chk("idle checksum", {24'h0, checksum}, 32'h0);

      // A write in WAIT is ignored.
      dn_wr = 1'b1; dn_addr = 17'h00010; dn_data = 8'hA5;
      @(posedge clk_sys); #1;
      dn_wr = 1'b0;
      chk("wait write rom_wr", {28'h0, rom_wr}, 32'h0);
      chk("wait write byte_count", {15'h0, byte_count}, 32'h0);

      // Window boundaries and out-of-range addresses.
      begin_load();
      sb_on = 1'b0;
      for (int i = 0; i < 12; i++) begin
         dn_wr = 1'b1; dn_addr = vt[i].addr; dn_data = vt[i].data;
         @(posedge clk_sys); #1;
         dn_wr = 1'b0;
         chk("vec rom_wr", {28'h0, rom_wr}, {28'h0, vt[i].exp_wr});
         if (vt[i].exp_wr != 4'b0000) begin
            chk("vec rom_addr", {19'h0, rom_addr}, {19'h0, vt[i].exp_addr});
            chk("vec rom_data", {24'h0, rom_data}, {24'h0, vt[i].data});
            m_sum = m_sum + vt[i].data;
         end else begin
            m_range = 1'b1;
         end
         chk("vec byte_count", {15'h0, byte_count}, {15'h0, vt[i].exp_count});
      end
      m_count = 9;
      @(negedge clk_sys);
      sb_on = 1'b1;
      dn_download = 1'b0;
      @(posedge clk_sys); #1;
      expect_release("table");

      // A write in RUN is ignored.
      dn_wr = 1'b1; dn_addr = 17'h00020; dn_data = 8'h3C;
      @(posedge clk_sys); #1;
      dn_wr = 1'b0;
      chk("run write rom_wr", {28'h0, rom_wr}, 32'h0);
      chk("run write byte_count", {15'h0, byte_count}, 32'd9);
      chk("run write core_reset_n", {31'h0, core_reset_n}, 32'h1);

      // Asynchronous reset in the middle of a load.
      begin_load();
      load_bytes(5, 8'h00, 1'b0);
      #2 Reset_n = 1'b0; dn_download = 1'b0;
      #1;
      chk("async rst rom_wr", {28'h0, rom_wr}, 32'h0);
      chk("async rst rom_addr", {19'h0, rom_addr}, 32'h0);
      chk("async rst rom_data", {24'h0, rom_data}, 32'h0);
      chk("async rst busy", {31'h0, busy}, 32'h0);
      chk("async rst byte_count", {15'h0, byte_count}, 32'h0);
      chk("async rst checksum", {24'h0, checksum}, 32'h0);
      sb_q.delete();
      #3 Reset_n = 1'b1;
      @(posedge clk_sys); #1;

      // Full load, final byte coincident with download falling.
      begin_load();
      load_bytes(FULL, 8'h5A, 1'b1);
      expect_release("full");

      // One byte short.
      begin_load();
      load_bytes(FULL - 1, 8'h5A, 1'b1);
      expect_release("short");

      // Abort during SETTLE, then a fresh full load.
      begin_load();
      load_bytes(10, 8'h00, 1'b1);
      repeat (S / 2) @(posedge clk_sys);
      #1;
      chk("mid settle core_reset_n", {31'h0, core_reset_n}, 32'h0);
      chk("mid settle busy", {31'h0, busy}, 32'h1);
      begin_load();
      load_bytes(FULL, 8'h5A, 1'b1);
      expect_release("fresh");

      // Abort from RUN; checksum stream summing to 5B.
      begin_load();
      load_bytes(FULL, 8'h5B, 1'b1);
      expect_release("cksum");
      chk("cksum value", {24'h0, checksum}, CK ? 32'h5B : 32'h0);
      chk("cksum load_err", {31'h0, load_err}, CK ? 32'h1 : 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
